// File: rtl/uart_cmd_ctrl.sv
// UART command frame controller: A5 CMD ADDR DATA CHK frames
// drive RAM writes, RAM-to-LED reads and direct LED loads.
module uart_cmd_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1200000
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  output logic              rts_n,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        leds,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] C_WR  = 8'h01;
  localparam logic [7:0] C_RD  = 8'h02;
  localparam logic [7:0] C_LED = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_RD_WAIT
  } state_e;

  state_e            state_q;
  logic [7:0]        cmd_q;
  logic [7:0]        addr_q;
  logic [7:0]        data_q;
  logic [TW-1:0]     tmo_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic [7:0]        leds_q;
  logic              frame_err_q;
  logic [7:0]        err_cnt_q;

  logic in_frame;
  logic cmd_ok;
  logic chk_ok;
  logic abort;

  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

  assign cmd_ok = (cmd_q == C_WR) || (cmd_q == C_RD) ||
                  (cmd_q == C_LED);

  assign chk_ok = cmd_ok &&
                  (rx_data == (cmd_q ^ addr_q ^ data_q));

  // rx_error wins over a same-cycle byte; timeout only when no byte arrives
  assign abort = in_frame &&
                 (rx_error ||
                  (!rx_valid && tmo_q == TMO) ||
                  (rx_valid && state_q == S_CHK && !chk_ok));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      leds_q      <= 8'h01;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      ram_we_q    <= 1'b0;
      frame_err_q <= abort;

      if (abort && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;

      if (!in_frame || rx_valid)
        tmo_q <= '0;
      else if (tmo_q != TMO)
        tmo_q <= tmo_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC)
            state_q <= S_CMD;
        end
        S_CMD: begin
          if (abort) state_q <= S_IDLE;
          else if (rx_valid) begin
            cmd_q   <= rx_data;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (abort) state_q <= S_IDLE;
          else if (rx_valid) begin
            addr_q  <= rx_data;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (abort) state_q <= S_IDLE;
          else if (rx_valid) begin
            data_q  <= rx_data;
            state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (abort) state_q <= S_IDLE;
          else if (rx_valid) begin
            state_q <= S_EXEC;
            ram_we_q <= (cmd_q == C_WR);
            if (cmd_q == C_WR || cmd_q == C_RD)
              ram_addr_q <= ADDR_W'(addr_q);
            if (cmd_q == C_WR)
              ram_wdata_q <= data_q;
          end
        end
        S_EXEC: begin
          if (cmd_q == C_LED)
            leds_q <= data_q;
          state_q <= (cmd_q == C_RD) ? S_RD_WAIT : S_IDLE;
        end
        S_RD_WAIT: begin
          leds_q  <= ram_rdata;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rts_n     = (state_q == S_EXEC) || (state_q == S_RD_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign leds      = leds_q;
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule
